// File: rtl/gate_tt_sequencer.sv
// ---------------------------------------------------------------------------
// gate_tt_sequencer
//
// Exhaustive truth-table checker for one combinational gate-under-test (GUT).
// A sweep drives every input vector 0 .. 2**N_IN-1 onto gut_in. Each vector
// is held for SETTLE_CYCLES edges and then sampled on one SAMPLE edge, where
// gut_out is compared with EXP_TABLE[vector]. At the end of the sweep the
// block pulses done and reports pass, the mismatch count and the index of
// the first failing vector.
//
// Parameters
//   N_IN           GUT input count (1..4); the sweep covers 2**N_IN vectors
//   EXP_TABLE      expected GUT output, bit k = expected output for vector k
//   SETTLE_CYCLES  edges each vector is held before it is sampled (>= 1)
//
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active-high
//   start        in   1        begin a sweep; only looked at while IDLE
//   gut_in       out  N_IN     GUT input drive (bit0 = A, bit1 = B, ...)
//   gut_out      in   1        GUT output, sampled directly (same clock domain)
//   busy         out  1        high while a sweep is in progress
//   done         out  1        one-cycle pulse at the end of a sweep
//   pass         out  1        last sweep had no mismatches; valid from done
//   err_count    out  N_IN+1   mismatches in the current / last sweep
//   first_fail   out  N_IN     first mismatching vector (valid if err_count!=0)
//   dbg_state_o  out  2        current FSM state, for checkers and debug
//
// Handshake: start is a plain level, not a valid/ready pair. It is accepted
// on any edge where the FSM is IDLE (including the done cycle) and ignored
// on every other edge; busy is the only "not ready" indication.
// ---------------------------------------------------------------------------
module gate_tt_sequencer #(
    parameter int                  N_IN          = 2,
    parameter logic [2**N_IN-1:0]  EXP_TABLE     = 4'b1000,
    parameter int                  SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] gut_in,
    input  logic            gut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic [1:0]      dbg_state_o
);

    localparam int EW    = N_IN + 1;
    // Counter must reach SETTLE_CYCLES (it keeps counting on the edge that
    // leaves SETTLE), so size it for SETTLE_CYCLES rather than SETTLE_CYCLES-1.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(2**N_IN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic [N_IN-1:0]   idx_q,        idx_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [N_IN-1:0]   gut_in_q,     gut_in_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              pass_q,       pass_d;
    logic [N_IN:0]     err_q,        err_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;

    logic              mismatch;

    // Only meaningful in SAMPLE; harmless elsewhere.
    assign mismatch = (gut_out != EXP_TABLE[idx_q]);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            gut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            gut_in_q     <= gut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        gut_in_d     = gut_in_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;

        unique case (state_q)
            ST_IDLE: begin
                // done is a single-cycle pulse: any edge spent in IDLE ends it.
                done_d = 1'b0;
                if (start) begin
                    gut_in_d     = '0;
                    idx_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    // At most 2**N_IN increments per sweep, which fits N_IN+1
                    // bits, so no saturation logic is needed.
                    err_d = err_q + EW'(1);
                    if (err_q == '0) begin
                        first_fail_d = idx_q;
                    end
                end

                if (idx_q != IDX_LAST) begin
                    idx_d    = idx_q + N_IN'(1);
                    gut_in_d = idx_q + N_IN'(1);
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    // Last vector: gut_in keeps driving it after the sweep.
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && !mismatch;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign gut_in      = gut_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign first_fail  = first_fail_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate_tt_sequencer
//
// Directed bench for gate_tt_sequencer with default parameters (2-input AND
// truth table, 2 settle cycles). A small behavioural GUT feeds gut_out; its
// mode selects a correct AND, a NAND (every vector wrong) or a stuck-at-0
// output (only vector 3 wrong). Expected values are worked out by hand from
// the sweep timing: vector k is sampled on edge 3*(k+1) after the start edge
// and done is high after edge 12.
// ---------------------------------------------------------------------------
module tb_gate_tt_sequencer;

    localparam int N_IN = 2;

    localparam int MODE_AND   = 0;
    localparam int MODE_NAND  = 1;
    localparam int MODE_STUCK = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT and GUT model
    // -----------------------------------------------------------------------
    logic            start = 1'b0;
    logic [N_IN-1:0] gut_in;
    logic            gut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic [1:0]      dbg_state;

    int gut_mode = MODE_AND;

    always_comb begin
        gut_out = 1'b0;
        case (gut_mode)
            MODE_AND:  gut_out = &gut_in;
            MODE_NAND: gut_out = ~&gut_in;
            default:   gut_out = 1'b0;
        endcase
    end

    gate_tt_sequencer #(
        .N_IN          (N_IN),
        .EXP_TABLE     (4'b1000),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .gut_in      (gut_in),
        .gut_out     (gut_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .first_fail  (first_fail),
        .dbg_state_o (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " gut_in"},     32'(gut_in),     32'd0);
        check_eq({tag, " busy"},       32'(busy),       32'd0);
        check_eq({tag, " done"},       32'(done),       32'd0);
        check_eq({tag, " pass"},       32'(pass),       32'd0);
        check_eq({tag, " err_count"},  32'(err_count),  32'd0);
        check_eq({tag, " first_fail"}, 32'(first_fail), 32'd0);
        check_eq({tag, " state"},      32'(dbg_state),  32'(ST_IDLE));
    endtask

    // -----------------------------------------------------------------------
    // Driver: one full sweep. Called just after a falling edge. Raises start
    // so the next rising edge is the start edge (edge 0), then checks the
    // outputs after every edge up to edge 12 (done cycle).
    //   repulse   : also raise start for edges 4 and 12 (must be ignored)
    //   post_idle : check that edge 13 leaves the block idle with done low;
    //               when 0 the task returns in the done cycle so the caller
    //               can start the next sweep back to back.
    // -----------------------------------------------------------------------
    task automatic do_sweep(input string tag, input bit repulse,
                            input bit post_idle, input int exp_err,
                            input int exp_ff, input bit exp_pass);
        int exp_gut;
        logic [1:0] exp_state;

        start = 1'b1;
        @(negedge clk);           // edge 0 has happened
        start = 1'b0;
        check_eq({tag, " e0 gut_in"}, 32'(gut_in),    32'd0);
        check_eq({tag, " e0 busy"},   32'(busy),      32'd1);
        check_eq({tag, " e0 done"},   32'(done),      32'd0);
        check_eq({tag, " e0 err"},    32'(err_count), 32'd0);
        check_eq({tag, " e0 pass"},   32'(pass),      32'd0);
        check_eq({tag, " e0 state"},  32'(dbg_state), 32'(ST_SETTLE));

        for (int e = 1; e <= 12; e++) begin
            if (repulse) start = (e == 4 || e == 12);
            @(negedge clk);       // edge e has happened
            start = 1'b0;
            exp_gut = (e / 3 > 3) ? 3 : e / 3;
            if (e == 12)         exp_state = ST_IDLE;
            else if (e % 3 == 2) exp_state = ST_SAMPLE;
            else                 exp_state = ST_SETTLE;
            check_eq($sformatf("%s e%0d gut_in", tag, e), 32'(gut_in), 32'(exp_gut));
            check_eq($sformatf("%s e%0d busy", tag, e),   32'(busy),   32'(e != 12));
            check_eq($sformatf("%s e%0d done", tag, e),   32'(done),   32'(e == 12));
            check_eq($sformatf("%s e%0d state", tag, e),  32'(dbg_state), 32'(exp_state));
        end

        check_eq({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        check_eq({tag, " pass"},      32'(pass),      32'(exp_pass));
        if (exp_err != 0)
            check_eq({tag, " first_fail"}, 32'(first_fail), 32'(exp_ff));

        if (post_idle) begin
            @(negedge clk);       // edge 13
            check_eq({tag, " e13 done"},  32'(done),      32'd0);
            check_eq({tag, " e13 busy"},  32'(busy),      32'd0);
            check_eq({tag, " e13 state"}, 32'(dbg_state), 32'(ST_IDLE));
            check_eq({tag, " e13 pass"},  32'(pass),      32'(exp_pass));
            check_eq({tag, " e13 gut_in"}, 32'(gut_in),   32'd3);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int done_seen;

        // Reset state.
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset idle");

        // 1: correct AND gate.
        gut_mode = MODE_AND;
        do_sweep("t1_and", 1'b0, 1'b1, 0, 0, 1'b1);

        // 2: NAND gate, every vector wrong.
        gut_mode = MODE_NAND;
        do_sweep("t2_nand", 1'b0, 1'b1, 4, 0, 1'b0);

        // 3: output stuck at 0, only vector 3 wrong.
        gut_mode = MODE_STUCK;
        do_sweep("t3_stuck0", 1'b0, 1'b1, 1, 3, 1'b0);

        // 4: start re-pulsed at edges 4 and 12, ignored.
        gut_mode = MODE_AND;
        do_sweep("t4_repulse", 1'b1, 1'b1, 0, 0, 1'b1);

        // 5: asynchronous reset after edge 7 aborts the sweep.
        gut_mode = MODE_NAND;
        start = 1'b1;
        @(negedge clk);           // edge 0
        start = 1'b0;
        repeat (7) @(negedge clk); // edges 1..7
        check_eq("t5 pre_rst gut_in", 32'(gut_in), 32'd2);
        check_eq("t5 pre_rst busy",   32'(busy),   32'd1);
        #2;                       // mid low phase, no clock edge involved
        rst = 1'b1;
        #1;
        check_reset_outputs("t5 async");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check_eq("t5 no done after abort", 32'(done_seen), 32'd0);
        check_reset_outputs("t5 idle after abort");
        gut_mode = MODE_AND;
        do_sweep("t5_clean", 1'b0, 1'b1, 0, 0, 1'b1);

        // 6: start held through the done cycle -> back-to-back sweeps. The
        // first sweep (NAND) leaves err_count=4; the second sweep's edge-0
        // checks show err_count and pass cleared by the restart.
        gut_mode = MODE_NAND;
        do_sweep("t6_first", 1'b0, 1'b0, 4, 0, 1'b0);
        gut_mode = MODE_AND;
        do_sweep("t6_second", 1'b0, 1'b1, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
